// File: rtl/enigma_host_ctrl_if.sv
// rtl/enigma_host_ctrl_if.sv - host-side config, input and output streams of enigma_host_ctrl
interface enigma_host_ctrl_if;
  logic        cfg_valid;
  logic [14:0] cfg_key;
  logic [1:0]  cfg_ra;
  logic [1:0]  cfg_rb;
  logic [1:0]  cfg_rc;
  logic        cfg_ready;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  modport master (
    output cfg_valid, cfg_key, cfg_ra, cfg_rb, cfg_rc, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_valid, cfg_key, cfg_ra, cfg_rb, cfg_rc, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/enigma_host_ctrl.sv
// rtl/enigma_host_ctrl.sv - host initiator feeding ASCII characters through the enigma rotor core
module enigma_host_ctrl #(
  parameter int LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  enigma_host_ctrl_if.slave   host,
  output logic [14:0]         enc_key,
  output logic [1:0]          enc_ra_cfg,
  output logic [1:0]          enc_rb_cfg,
  output logic [1:0]          enc_rc_cfg,
  output logic                enc_load_key,
  output logic [4:0]          enc_char_in,
  output logic                enc_new_char,
  input  logic [4:0]          enc_char_out,
  output logic                keyed,
  output logic                bad_char
);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, EMIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;

  logic is_upper;
  logic is_lower;
  assign is_upper = (host.in_data >= 8'h41) && (host.in_data <= 8'h5A);
  assign is_lower = (host.in_data >= 8'h61) && (host.in_data <= 8'h7A);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      enc_key        <= '0;
      enc_ra_cfg     <= '0;
      enc_rb_cfg     <= '0;
      enc_rc_cfg     <= '0;
      enc_load_key   <= 1'b0;
      enc_char_in    <= '0;
      enc_new_char   <= 1'b0;
      keyed          <= 1'b0;
      bad_char       <= 1'b0;
      host.cfg_ready <= 1'b0;
      host.in_ready  <= 1'b0;
      host.out_valid <= 1'b0;
      host.out_data  <= '0;
    end else begin
      enc_load_key <= 1'b0;
      enc_new_char <= 1'b0;
      case (state)
        IDLE: begin
          // Configuration is checked first so it wins a simultaneous character.
          if (host.cfg_valid && host.cfg_ready) begin
            enc_key        <= host.cfg_key;
            enc_ra_cfg     <= host.cfg_ra;
            enc_rb_cfg     <= host.cfg_rb;
            enc_rc_cfg     <= host.cfg_rc;
            enc_load_key   <= 1'b1;
            host.cfg_ready <= 1'b0;
            host.in_ready  <= 1'b0;
            state          <= LOAD;
          end else if (host.in_valid && host.in_ready) begin
            host.cfg_ready <= 1'b0;
            host.in_ready  <= 1'b0;
            if (is_upper) begin
              enc_char_in  <= 5'(host.in_data - 8'h41);
              enc_new_char <= 1'b1;
              state        <= FEED;
            end else if (is_lower) begin
              enc_char_in  <= 5'(host.in_data - 8'h61);
              enc_new_char <= 1'b1;
              state        <= FEED;
            end else begin
              host.out_data  <= host.in_data;
              host.out_valid <= 1'b1;
              state          <= EMIT;
            end
          end else begin
            host.cfg_ready <= 1'b1;
            host.in_ready  <= keyed;
          end
        end
        LOAD: begin
          keyed          <= 1'b1;
          host.cfg_ready <= 1'b1;
          host.in_ready  <= 1'b1;
          state          <= IDLE;
        end
        FEED: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (enc_char_out > 5'd25) begin
              host.out_data <= 8'h3F;
              bad_char      <= 1'b1;
            end else begin
              host.out_data <= {3'b000, enc_char_out} + 8'h41;
            end
            host.out_valid <= 1'b1;
            state          <= EMIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        EMIT: begin
          if (host.out_ready) begin
            host.out_valid <= 1'b0;
            host.cfg_ready <= 1'b1;
            host.in_ready  <= keyed;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/enigma_host_ctrl.md
# enigma_host_ctrl

Host-side initiator for the `enigma` rotor core. It takes an 8-bit ASCII character stream and a key/rotor configuration over valid/ready handshakes. It drives the core's key-load and per-character pulse interface, captures the substituted letter after a fixed core latency, and returns it as ASCII on a valid/ready output stream. It sits between the message source (UART, DMA or bench) and the `enigma` instance; non-letters bypass the core unchanged.

## Interface
- `LAT`, default 1: cycles from the `enc_new_char` pulse to a valid `enc_char_out`; legal range 1–15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration request.
- `cfg_key` in 15: three 5-bit start positions.
- `cfg_ra`, `cfg_rb`, `cfg_rc` in 2 each: rotor selections.
- `cfg_ready` out 1: configuration can be accepted.
- `in_valid` in 1: input character valid.
- `in_data` in 8: ASCII character.
- `in_ready` out 1: input character can be accepted.
- `out_valid` out 1: output character valid.
- `out_data` out 8: ASCII result.
- `out_ready` in 1: downstream accepts the output.
- `enc_key` out 15, `enc_ra_cfg`/`enc_rb_cfg`/`enc_rc_cfg` out 2 each: registered copies of the last accepted configuration, driven to the core.
- `enc_load_key` out 1: one-cycle key-load strobe.
- `enc_char_in` out 5: letter index 0–25.
- `enc_new_char` out 1: one-cycle character strobe.
- `enc_char_out` in 5: substituted index from the core.
- `keyed` out 1: a configuration has been loaded since reset.
- `bad_char` out 1: sticky flag; core returned an index above 25.

## Operation
- **States:** IDLE, LOAD, FEED, WAIT, EMIT.
- **IDLE:**
  - `cfg_ready`=1.
  - `in_ready`=`keyed`.
  - If `cfg_valid` and `in_valid` are both high in the same cycle, the configuration wins. The character is not accepted that cycle.
- **Config handshake (`cfg_valid`&`cfg_ready`):**
  - Latch `cfg_key` and the three rotor selections into the `enc_*` registers.
  - Go to LOAD.
- **LOAD:**
  - `enc_load_key`=1 for exactly this cycle.
  - Set `keyed`.
  - Return to IDLE.
- **Character handshake (`in_valid`&`in_ready`):**
  - 'A'–'Z' (0x41–0x5A): `enc_char_in`←`in_data`−0x41, go to FEED.
  - 'a'–'z' (0x61–0x7A): folded to uppercase, `enc_char_in`←`in_data`−0x61, go to FEED.
  - Any other byte: `out_data`←`in_data`, go directly to EMIT. No strobe to the core.
- **FEED:**
  - `enc_new_char`=1 for exactly this cycle.
  - Load the wait counter with `LAT`−1.
  - Go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - On the cycle the counter reads 0, sample `enc_char_out`:
    - Value ≤25: `out_data`←value+0x41.
    - Value >25: `out_data`←0x3F ('?') and set `bad_char`.
  - Go to EMIT.
- **EMIT:**
  - `out_valid`=1, `out_data` stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` and `cfg_ready` stay 0 in every state except IDLE.
- **Hold rules:**
  - `enc_char_in` holds its value until the next letter is accepted.
  - `enc_key`/`enc_r*_cfg` hold until the next configuration.
- **Reset:** from any state, go to IDLE. All of the following clear to 0:
  - `enc_key`, all `enc_r*_cfg`, `enc_char_in`, `enc_load_key`, `enc_new_char`
  - `out_valid`, `out_data`
  - `keyed`, `bad_char`
  - `cfg_ready` and `in_ready` are 0 during reset.
  - A character in flight when reset hits is dropped; nothing is emitted for it.

## Timing
- Letter accepted on edge ending cycle N:
  - `enc_new_char` is high in cycle N+1.
  - `enc_char_out` is sampled on the edge ending cycle N+1+`LAT`.
  - `out_valid` rises in cycle N+2+`LAT`.
- Non-letter accepted in cycle N: `out_valid` rises in cycle N+1.
- Config accepted in cycle N:
  - `enc_key`/`enc_r*_cfg` update at the start of N+1.
  - `enc_load_key` is high in N+1.
  - `keyed`=1 and `cfg_ready`=1 from N+2.
- After the output handshake in cycle M, `in_ready`=1 in cycle M+1.
- Letter throughput is one character per `LAT`+3 cycles with `out_ready` held high.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `reset` mid-cycle, then release.
  - All outputs 0.
  - `in_valid`=1 with 'A' is not accepted (`keyed`=0).
  - `cfg_ready`=1 after release.
- **Config load:** `cfg_key`=0, rotors 0/1/2.
  - Exactly one `enc_load_key` pulse.
  - `enc_key`=0, `enc_ra_cfg`=0, `enc_rb_cfg`=1, `enc_rc_cfg`=2.
  - `keyed`=1.
- **Letter path:** `LAT`=1; send 'A' (0x41); the core stub returns 17.
  - `enc_char_in`=0.
  - One `enc_new_char` pulse.
  - `out_data`=0x52 ('R'), with `out_valid` rising exactly 3 cycles after acceptance.
  - Repeat with 'b' (0x62): `enc_char_in`=1.
- **Bypass and error:**
  - Send 0x20: `out_data`=0x20 one cycle later, no `enc_new_char`.
  - Stub returns 30: `out_data`=0x3F, `bad_char`=1, and `bad_char` stays 1 through further traffic until reset.
- **Backpressure and priority:**
  - Hold `out_ready`=0 for 5 cycles: `out_data` stable, `in_ready`=0 throughout.
  - `cfg_valid` and `in_valid` high in the same IDLE cycle: config is accepted first, and the character is accepted two cycles later.
- **Reset mid-operation:** assert `reset` during WAIT with `LAT`=4.
  - No `out_valid` afterwards.
  - `keyed`=0; a new config is required before characters are accepted.
